// File: rtl/frost32_mem_access_ctrl_pkg.sv
// Shared types and helpers for the Frost32 memory access controller.
// The core's access type/size codes are mirrored here so the block stands alone.
package frost32_mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic       DIAT_READ  = 1'b0;
    localparam logic       DIAT_WRITE = 1'b1;
    localparam logic [1:0] DIAS_8     = 2'b00;
    localparam logic [1:0] DIAS_16    = 2'b01;
    localparam logic [1:0] DIAS_32    = 2'b10;

    function automatic int tmo_cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

    // Byte mask of the access before lane shifting; zero for the illegal size code.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            DIAS_8:  m = 4'b0001;
            DIAS_16: m = 4'b0011;
            DIAS_32: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/frost32_mem_access_ctrl_lane_steer.sv
// Combinational byte-lane steering: lane enables and write data per beat,
// plus read merge of the two bus words into a right-justified value.
module frost32_mem_access_ctrl_lane_steer
    import frost32_mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        beat,
    input  logic [31:0] wdata,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic [3:0]  be,
    output logic [31:0] steered_wdata,
    output logic [31:0] merged_rdata,
    output logic        split
);

    logic [3:0]  mask_s;
    logic [7:0]  span_s;
    logic [5:0]  sh_s;
    logic [63:0] pair_s;
    logic [31:0] keep_s;

    // Lane span over two words; the upper nibble belongs to the second beat.
    always_comb begin
        mask_s = size_mask(size);
        span_s = {4'b0000, mask_s} << off;
        sh_s   = {1'b0, off, 3'b000};
        split  = (span_s[7:4] != 4'b0000);
        if (beat) begin
            be            = span_s[7:4];
            steered_wdata = wdata >> (6'd32 - sh_s);
        end else begin
            be            = span_s[3:0];
            steered_wdata = wdata << sh_s;
        end
        pair_s       = {word1, word0} >> sh_s;
        keep_s       = {{8{mask_s[3]}}, {8{mask_s[2]}}, {8{mask_s[1]}}, {8{mask_s[0]}}};
        merged_rdata = pair_s[31:0] & keep_s;
    end

endmodule

// File: rtl/frost32_mem_access_ctrl.sv
// Frost32 memory access controller: turns core byte-addressed requests into one or
// two word-bus beats with byte enables, req/ack handshake and per-beat timeout.
module frost32_mem_access_ctrl
    import frost32_mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_access_type,
    input  logic [1:0]  cpu_access_size,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int            CW       = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state_r;
    logic [1:0]    off_r, size_r;
    logic          type_r, split_r;
    logic [31:0]   wdata_r, word0_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r, done_r, err_r, mem_req_r, mem_we_r;
    logic [31:0]   rdata_r, mem_wdata_r;
    logic [29:0]   mem_addr_r;
    logic [3:0]    mem_be_r;

    logic [1:0]    sel_off_s, sel_size_s;
    logic [31:0]   sel_wdata_s, sel_word0_s;
    logic          sel_beat_s, tmo_hit_s;
    logic [3:0]    be_s;
    logic [31:0]   wd_s, merged_s;
    logic          split_s;

    // In idle the steer looks at the live request (beat0); afterwards at the latched one (beat1).
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_off_s   = cpu_addr[1:0];
            sel_size_s  = cpu_access_size;
            sel_wdata_s = cpu_wdata;
            sel_beat_s  = 1'b0;
        end else begin
            sel_off_s   = off_r;
            sel_size_s  = size_r;
            sel_wdata_s = wdata_r;
            sel_beat_s  = 1'b1;
        end
        if (state_r == ST_BEAT1) begin
            sel_word0_s = word0_r;
        end else begin
            sel_word0_s = mem_rdata;
        end
        tmo_hit_s = (TIMEOUT_CYCLES != 0) && (cnt_r == TMO_LAST);
    end

    frost32_mem_access_ctrl_lane_steer u_steer (
        .off           (sel_off_s),
        .size          (sel_size_s),
        .beat          (sel_beat_s),
        .wdata         (sel_wdata_s),
        .word0         (sel_word0_s),
        .word1         (mem_rdata),
        .be            (be_s),
        .steered_wdata (wd_s),
        .merged_rdata  (merged_s),
        .split         (split_s)
    );

    // Access FSM with registered core and bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            off_r       <= 2'b00;
            size_r      <= 2'b00;
            type_r      <= 1'b0;
            split_r     <= 1'b0;
            wdata_r     <= 32'h0;
            word0_r     <= 32'h0;
            cnt_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= 32'h0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 30'h0;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cpu_req) begin
                        off_r   <= cpu_addr[1:0];
                        size_r  <= cpu_access_size;
                        type_r  <= cpu_access_type;
                        wdata_r <= cpu_wdata;
                        split_r <= split_s;
                        busy_r  <= 1'b1;
                        if (cpu_access_size == 2'b11) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                            rdata_r <= 32'h0;
                        end else begin
                            state_r     <= ST_BEAT0;
                            cnt_r       <= '0;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= cpu_access_type;
                            mem_addr_r  <= cpu_addr[31:2];
                            mem_be_r    <= be_s;
                            mem_wdata_r <= wd_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BEAT0, ST_BEAT1: begin
                    if (mem_ack) begin
                        if ((state_r == ST_BEAT0) && split_r) begin
                            state_r     <= ST_BEAT1;
                            word0_r     <= mem_rdata;
                            cnt_r       <= '0;
                            mem_addr_r  <= mem_addr_r + 30'd1;
                            mem_be_r    <= be_s;
                            mem_wdata_r <= wd_s;
                        end else begin
                            state_r     <= ST_DONE;
                            done_r      <= 1'b1;
                            err_r       <= 1'b0;
                            rdata_r     <= (type_r == DIAT_WRITE) ? 32'h0 : merged_s;
                            mem_req_r   <= 1'b0;
                            mem_we_r    <= 1'b0;
                            mem_be_r    <= 4'b0000;
                            mem_wdata_r <= 32'h0;
                        end
                    end else if (tmo_hit_s) begin
                        state_r     <= ST_DONE;
                        done_r      <= 1'b1;
                        err_r       <= 1'b1;
                        rdata_r     <= 32'h0;
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_be_r    <= 4'b0000;
                        mem_wdata_r <= 32'h0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_busy    = busy_r;
    assign cpu_done    = done_r;
    assign cpu_err     = err_r;
    assign cpu_rdata   = rdata_r;
    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_byte_en = mem_be_r;
    assign mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_frost32_mem_access_ctrl.sv
// Bench for frost32_mem_access_ctrl: directed scenarios plus random accesses checked
// against a byte-by-byte model of which word and lane each accessed byte lands in.
module tb_frost32_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_access_type;
    logic [1:0]  cpu_access_size;
    logic        cpu_busy, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    frost32_mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_access_type(cpu_access_type), .cpu_access_size(cpu_access_size),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_byte_en(mem_byte_en),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // One access; every call starts and ends 1 time unit after a rising edge.
    task automatic run_access(input logic [31:0] addr, input logic we, input logic [1:0] size,
                              input logic [31:0] wd, input int dly,
                              input logic [31:0] w0, input logic [31:0] w1);
        logic [3:0]  exp_be[2];
        logic [31:0] exp_wd[2];
        logic [29:0] exp_addr[2];
        logic [31:0] words[2];
        logic [31:0] exp_rd;
        logic [31:0] a;
        int          nb, nbeats, bt, ln;
        words[0] = w0; words[1] = w1;
        exp_be[0] = 4'h0; exp_be[1] = 4'h0; exp_wd[0] = 32'h0; exp_wd[1] = 32'h0;
        exp_addr[0] = addr[31:2]; exp_addr[1] = addr[31:2] + 30'd1;
        exp_rd = 32'h0;
        nb = 1 << size;
        for (int i = 0; i < nb; i++) begin
            a  = addr + 32'(i);
            bt = (a[31:2] != addr[31:2]) ? 1 : 0;
            ln = int'(a[1:0]);
            exp_be[bt][ln]        = 1'b1;
            exp_wd[bt][8*ln +: 8] = wd[8*i +: 8];
            exp_rd[8*i +: 8]      = words[bt][8*ln +: 8];
        end
        if (we) exp_rd = 32'h0;
        nbeats = (exp_be[1] != 4'h0) ? 2 : 1;

        cpu_req = 1'b1; cpu_addr = addr; cpu_access_type = we;
        cpu_access_size = size; cpu_wdata = wd;
        @(posedge clk); #1;
        total++;
        if (cpu_busy !== 1'b1) begin bad++; $display("FAIL busy_after_accept: got %b want 1", cpu_busy); end
        for (int b = 0; b < nbeats; b++) begin
            for (int w = 0; w <= dly; w++) begin
                total++;
                if ({mem_req, mem_we, mem_addr, mem_byte_en} !== {1'b1, we, exp_addr[b], exp_be[b]}) begin
                    bad++;
                    $display("FAIL beat%0d_fields @%h: got req=%b we=%b addr=%h be=%b want req=1 we=%b addr=%h be=%b",
                             b, addr, mem_req, mem_we, mem_addr, mem_byte_en, we, exp_addr[b], exp_be[b]);
                end
                if (we) begin
                    total++;
                    if ((mem_wdata & lane_mask(exp_be[b])) !== exp_wd[b]) begin
                        bad++;
                        $display("FAIL beat%0d_wdata @%h: got %h want %h (lanes %b)", b, addr,
                                 mem_wdata & lane_mask(exp_be[b]), exp_wd[b], exp_be[b]);
                    end
                end
                total++;
                if (cpu_done !== 1'b0) begin bad++; $display("FAIL early_done @%h: got %b want 0", addr, cpu_done); end
                if (w == dly) begin
                    mem_ack = 1'b1; mem_rdata = words[b];
                end
                @(posedge clk); #1;
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
        end
        total++;
        if ({cpu_done, cpu_err, mem_req, cpu_rdata} !== {1'b1, 1'b0, 1'b0, exp_rd}) begin
            bad++;
            $display("FAIL completion @%h: got done=%b err=%b req=%b rdata=%h want done=1 err=0 req=0 rdata=%h",
                     addr, cpu_done, cpu_err, mem_req, cpu_rdata, exp_rd);
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({cpu_done, cpu_busy, cpu_rdata} !== {1'b0, 1'b0, exp_rd}) begin
            bad++;
            $display("FAIL after_done @%h: got done=%b busy=%b rdata=%h want done=0 busy=0 rdata=%h",
                     addr, cpu_done, cpu_busy, cpu_rdata, exp_rd);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({cpu_busy, cpu_done, cpu_err, cpu_rdata, mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata} !== 103'h0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b rdata=%h req=%b we=%b addr=%h be=%b wdata=%h want all 0",
                     cpu_busy, cpu_done, cpu_err, cpu_rdata, mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata);
        end
    endtask

    task automatic test_write32();
        run_access(32'h100, 1'b1, 2'b10, 32'hDEADBEEF, 0, 32'h0, 32'h0);
    endtask

    task automatic test_read8();
        run_access(32'h203, 1'b0, 2'b00, 32'h0, 0, 32'hAABBCCDD, 32'h0);
        total++;
        if (cpu_rdata !== 32'h000000AA) begin bad++; $display("FAIL read8_value: got %h want 000000aa", cpu_rdata); end
    endtask

    task automatic test_split_read();
        run_access(32'h102, 1'b0, 2'b10, 32'h0, 1, 32'h11223344, 32'h55667788);
        total++;
        if (cpu_rdata !== 32'h77881122) begin bad++; $display("FAIL split_read_value: got %h want 77881122", cpu_rdata); end
    endtask

    task automatic test_split_write_wrap();
        run_access(32'h7, 1'b1, 2'b01, 32'h0000BEEF, 0, 32'h0, 32'h0);
        run_access(32'hFFFFFFFE, 1'b0, 2'b10, 32'h0, 2, 32'hCAFE0000, 32'h0000F00D);
        total++;
        if (cpu_rdata !== 32'hF00DCAFE) begin bad++; $display("FAIL wrap_read_value: got %h want f00dcafe", cpu_rdata); end
    endtask

    task automatic test_timeout();
        int cnt = 0;
        cpu_req = 1'b1; cpu_addr = 32'h40; cpu_access_type = 1'b0; cpu_access_size = 2'b10;
        @(posedge clk); #1;
        while (mem_req === 1'b1 && cnt < 12) begin
            cnt++;
            @(posedge clk); #1;
        end
        total++;
        if (cnt != 4) begin bad++; $display("FAIL timeout_req_cycles: got %0d want 4", cnt); end
        total++;
        if ({cpu_done, cpu_err, cpu_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL timeout_pulse: got done=%b err=%b rdata=%h want done=1 err=1 rdata=0", cpu_done, cpu_err, cpu_rdata);
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({cpu_done, cpu_err, cpu_busy} !== 3'b000) begin
            bad++; $display("FAIL timeout_end: got done=%b err=%b busy=%b want 000", cpu_done, cpu_err, cpu_busy);
        end
    endtask

    task automatic test_illegal();
        cpu_req = 1'b1; cpu_addr = 32'h80; cpu_access_type = 1'b1; cpu_access_size = 2'b11;
        @(posedge clk); #1;
        total++;
        if ({mem_req, cpu_done, cpu_err, cpu_busy} !== 4'b0111) begin
            bad++; $display("FAIL illegal_size: got req=%b done=%b err=%b busy=%b want 0111", mem_req, cpu_done, cpu_err, cpu_busy);
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({mem_req, cpu_done, cpu_busy} !== 3'b000) begin
            bad++; $display("FAIL illegal_end: got req=%b done=%b busy=%b want 000", mem_req, cpu_done, cpu_busy);
        end
    endtask

    task automatic test_reset_mid_beat();
        int seen_done = 0;
        cpu_req = 1'b1; cpu_addr = 32'h102; cpu_access_type = 1'b0; cpu_access_size = 2'b10;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'h11223344;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 30'h41}) begin
            bad++; $display("FAIL mid_beat1: got req=%b addr=%h want req=1 addr=41", mem_req, mem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mem_req, cpu_busy} !== 2'b00) begin
            bad++; $display("FAIL async_reset: got req=%b busy=%b want 00", mem_req, cpu_busy);
        end
        cpu_req = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (cpu_done === 1'b1) seen_done++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (cpu_done === 1'b1) seen_done++;
        total++;
        if (seen_done != 0) begin bad++; $display("FAIL reset_no_done: got %0d done cycles want 0", seen_done); end
        test_write32();
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] addr;
            addr = $urandom;
            if (n % 8 == 0) addr[31:2] = 30'h3FFFFFFF;
            run_access(addr, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom,
                       $urandom_range(0, 3), $urandom, $urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        cpu_access_type = 1'b0; cpu_access_size = 2'b00; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_write32();
        test_read8();
        test_split_read();
        test_split_write_wrap();
        test_timeout();
        test_illegal();
        test_reset_mid_beat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
